// File: rtl/mm_bus_arbiter.sv
// Two-port round-robin arbiter for a shared memory-mapped slave.
// The grant is held for a whole transaction, and the bus outputs are registered.
module mm_bus_arbiter #(
    parameter int unsigned MM_ADDR_WIDTH = 8,
    parameter int unsigned MM_DATA_WIDTH = 16,
    parameter int unsigned HOLD_MAX      = 255
) (
    input  logic                     clk_sys_i,
    input  logic                     rst_i,
    input  logic                     m0_req_i,
    output logic                     m0_gnt_o,
    input  logic [MM_ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [MM_DATA_WIDTH-1:0] m0_wdata_i,
    input  logic                     m0_we_i,
    output logic [MM_DATA_WIDTH-1:0] m0_rdata_o,
    input  logic                     m1_req_i,
    output logic                     m1_gnt_o,
    input  logic [MM_ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [MM_DATA_WIDTH-1:0] m1_wdata_i,
    input  logic                     m1_we_i,
    output logic [MM_DATA_WIDTH-1:0] m1_rdata_o,
    output logic [MM_ADDR_WIDTH-1:0] mm_s_addr_o,
    output logic [MM_DATA_WIDTH-1:0] mm_s_wdata_o,
    output logic                     mm_s_we_o,
    input  logic [MM_DATA_WIDTH-1:0] mm_s_rdata_i,
    output logic                     hold_err_o
);

    localparam int unsigned CntW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CntW-1:0] HoldMaxC = CntW'(HOLD_MAX);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1, StGap} state_e;

    state_e                   state_q, state_d;
    logic                     last_grant_q, last_grant_d;
    logic [CntW-1:0]          hold_cnt_q, hold_cnt_d;
    logic                     hold_err_q, hold_err_d;
    logic [MM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MM_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                     we_q, we_d;
    logic                     waiting;

    assign waiting = (state_q == StGnt0 && m1_req_i) || (state_q == StGnt1 && m0_req_i);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        hold_cnt_d   = hold_cnt_q;
        hold_err_d   = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;

        unique case (state_q)
            StIdle: begin
                hold_cnt_d = '0;
                if (m0_req_i && m1_req_i) begin
                    state_d = last_grant_q ? StGnt0 : StGnt1;
                end else if (m0_req_i) begin
                    state_d = StGnt0;
                end else if (m1_req_i) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                addr_d  = m0_addr_i;
                wdata_d = m0_wdata_i;
                we_d    = m0_we_i & m0_req_i;
                if (!m0_req_i) begin
                    state_d      = StGap;
                    last_grant_d = 1'b0;
                end
            end
            StGnt1: begin
                addr_d  = m1_addr_i;
                wdata_d = m1_wdata_i;
                we_d    = m1_we_i & m1_req_i;
                if (!m1_req_i) begin
                    state_d      = StGap;
                    last_grant_d = 1'b1;
                end
            end
            StGap: begin
                state_d    = StIdle;
                hold_cnt_d = '0;
            end
            default: state_d = StIdle;
        endcase

        // Saturating count: the pulse fires only on the transition onto HOLD_MAX.
        if (waiting && HOLD_MAX != 0 && hold_cnt_q != HoldMaxC) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            hold_err_d = (hold_cnt_d == HoldMaxC);
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            hold_cnt_q   <= '0;
            hold_err_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            hold_cnt_q   <= hold_cnt_d;
            hold_err_q   <= hold_err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
        end
    end

    assign m0_gnt_o     = (state_q == StGnt0);
    assign m1_gnt_o     = (state_q == StGnt1);
    assign m0_rdata_o   = m0_gnt_o ? mm_s_rdata_i : '0;
    assign m1_rdata_o   = m1_gnt_o ? mm_s_rdata_i : '0;
    assign mm_s_addr_o  = addr_q;
    assign mm_s_wdata_o = wdata_q;
    assign mm_s_we_o    = we_q;
    assign hold_err_o   = hold_err_q;

endmodule

// File: tb/tb_mm_bus_arbiter.sv
// Bench for mm_bus_arbiter: directed scenarios plus random traffic,
// with every cycle checked against a transaction-level model of ownership.
module tb_mm_bus_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned HM = 8;

    logic          clk_sys_i = 1'b0;
    logic          rst_i;
    logic          m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic [DW-1:0] m0_wdata_i, m1_wdata_i;
    logic          m0_gnt_o, m1_gnt_o, mm_s_we_o, hold_err_o;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o, mm_s_wdata_o, mm_s_rdata_i;
    logic [AW-1:0] mm_s_addr_o;

    mm_bus_arbiter #(
        .MM_ADDR_WIDTH(AW),
        .MM_DATA_WIDTH(DW),
        .HOLD_MAX     (HM)
    ) dut (
        .clk_sys_i   (clk_sys_i),
        .rst_i       (rst_i),
        .m0_req_i    (m0_req_i),
        .m0_gnt_o    (m0_gnt_o),
        .m0_addr_i   (m0_addr_i),
        .m0_wdata_i  (m0_wdata_i),
        .m0_we_i     (m0_we_i),
        .m0_rdata_o  (m0_rdata_o),
        .m1_req_i    (m1_req_i),
        .m1_gnt_o    (m1_gnt_o),
        .m1_addr_i   (m1_addr_i),
        .m1_wdata_i  (m1_wdata_i),
        .m1_we_i     (m1_we_i),
        .m1_rdata_o  (m1_rdata_o),
        .mm_s_addr_o (mm_s_addr_o),
        .mm_s_wdata_o(mm_s_wdata_o),
        .mm_s_we_o   (mm_s_we_o),
        .mm_s_rdata_i(mm_s_rdata_i),
        .hold_err_o  (hold_err_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    int n_cmp = 0;
    int n_err = 0;

    // Model: who owns the bus, a one-cycle cool-down after release, and the wait tally.
    int            owner, last, waits;
    bit            cool, flagged, e_we, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1; last = 1; waits = 0; cool = 0; flagged = 0;
        e_we = 0; e_err = 0; e_addr = '0; e_wdata = '0;
    endtask

    task automatic model_step();
        bit [1:0] req;
        if (rst_i) begin
            model_reset();
            return;
        end
        req   = {m1_req_i, m0_req_i};
        e_we  = 0;
        e_err = 0;
        if (owner >= 0) begin
            e_addr  = (owner == 1) ? m1_addr_i : m0_addr_i;
            e_wdata = (owner == 1) ? m1_wdata_i : m0_wdata_i;
            if (req[owner]) e_we = (owner == 1) ? m1_we_i : m0_we_i;
            if (req[1-owner]) begin
                waits++;
                if (waits >= HM && !flagged) begin
                    e_err = 1;
                    flagged = 1;
                end
            end
            if (!req[owner]) begin
                last = owner;
                owner = -1;
                cool = 1;
            end
        end else if (cool) begin
            cool = 0; waits = 0; flagged = 0;
        end else begin
            waits = 0; flagged = 0;
            if (req == 2'b11) owner = 1 - last;
            else if (req[0]) owner = 0;
            else if (req[1]) owner = 1;
        end
    endtask

    task automatic check_all();
        check_eq("m0_gnt", m0_gnt_o, owner == 0);
        check_eq("m1_gnt", m1_gnt_o, owner == 1);
        check_eq("bus_addr", mm_s_addr_o, e_addr);
        check_eq("bus_wdata", mm_s_wdata_o, e_wdata);
        check_eq("bus_we", mm_s_we_o, e_we);
        check_eq("hold_err", hold_err_o, e_err);
        check_eq("m0_rdata", m0_rdata_o, (owner == 0) ? mm_s_rdata_i : '0);
        check_eq("m1_rdata", m1_rdata_o, (owner == 1) ? mm_s_rdata_i : '0);
    endtask

    task automatic tick();
        @(posedge clk_sys_i);
        model_step();
        @(negedge clk_sys_i);
        mm_s_rdata_i = DW'($urandom);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        m0_req_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_wdata_i = '0;
        m1_req_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_wdata_i = '0;
    endtask

    task automatic do_reset();
        rst_i = 1;
        idle_inputs();
        tick();
        tick();
        rst_i = 0;
    endtask

    int port_now, port_prev, prev_grant, held, n_grants, pulses, pulse_at;

    initial begin
        rst_i = 1;
        mm_s_rdata_i = '0;
        idle_inputs();
        model_reset();
        do_reset();
        check_eq("rst_gnt", {m1_gnt_o, m0_gnt_o}, 2'b00);

        // Single write from port 0.
        m0_req_i = 1; m0_addr_i = 8'h12; m0_wdata_i = 16'hBEEF;
        tick();
        check_eq("wr_gnt", m0_gnt_o, 1);
        m0_we_i = 1;
        tick();
        check_eq("wr_we", mm_s_we_o, 1);
        check_eq("wr_addr", mm_s_addr_o, 8'h12);
        check_eq("wr_data", mm_s_wdata_o, 16'hBEEF);
        m0_we_i = 0;
        tick();
        check_eq("wr_we_once", mm_s_we_o, 0);
        m0_req_i = 0;
        tick();
        tick();

        // Tie straight after reset: port 0 first, then a two-cycle gap before port 1.
        do_reset();
        m0_req_i = 1; m1_req_i = 1;
        tick();
        check_eq("tie_first", {m1_gnt_o, m0_gnt_o}, 2'b01);
        tick();
        m0_req_i = 0;
        tick();
        check_eq("tie_gap1", {m1_gnt_o, m0_gnt_o}, 2'b00);
        tick();
        check_eq("tie_gap2", {m1_gnt_o, m0_gnt_o}, 2'b00);
        tick();
        check_eq("tie_second", {m1_gnt_o, m0_gnt_o}, 2'b10);
        m1_req_i = 0;
        tick();
        tick();
        tick();

        // Fairness: both request continuously, each owner releasing after 4 cycles.
        m0_req_i = 1; m1_req_i = 1;
        port_prev = -1; prev_grant = -1; held = 0; n_grants = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            port_now = m0_gnt_o ? 0 : (m1_gnt_o ? 1 : -1);
            if (port_now >= 0 && port_prev < 0) begin
                if (prev_grant >= 0) check_eq("fair_alt", port_now, 1 - prev_grant);
                prev_grant = port_now;
                held = 0;
                n_grants++;
            end
            if (port_now >= 0) begin
                held++;
                if (held == 4) begin
                    if (port_now == 0) m0_req_i = 0;
                    else m1_req_i = 0;
                end
            end else begin
                m0_req_i = 1; m1_req_i = 1;
            end
            port_prev = port_now;
        end
        check_eq("fair_cnt", n_grants >= 6, 1);
        idle_inputs();
        tick();
        tick();
        tick();

        // Isolation: port 1 drives a write while port 0 owns the bus.
        m0_req_i = 1; m0_addr_i = 8'h21; m0_wdata_i = 16'h1234;
        tick();
        m1_req_i = 1; m1_we_i = 1; m1_addr_i = 8'h55; m1_wdata_i = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("iso_we", mm_s_we_o, 0);
            check_eq("iso_addr", mm_s_addr_o, 8'h21);
            check_eq("iso_rdata", m1_rdata_o, 0);
        end
        m1_we_i = 0;

        // Hold limit: port 1 keeps waiting while port 0 holds for 20 cycles.
        pulses = 0; pulse_at = 0;
        do_reset();
        m0_req_i = 1;
        tick();
        m1_req_i = 1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check_eq("hold_gnt", m0_gnt_o, 1);
            if (hold_err_o) begin
                pulses++;
                pulse_at = k;
            end
        end
        check_eq("hold_pulses", pulses, 1);
        check_eq("hold_pulse_at", pulse_at, HM);

        // Asynchronous reset in the middle of a write.
        m1_req_i = 0; m0_we_i = 1; m0_addr_i = 8'h3C; m0_wdata_i = 16'hA5A5;
        tick();
        check_eq("pre_rst_we", mm_s_we_o, 1);
        rst_i = 1;
        #1;
        check_eq("arst_gnt", m0_gnt_o, 0);
        check_eq("arst_we", mm_s_we_o, 0);
        check_eq("arst_addr", mm_s_addr_o, 0);
        check_eq("arst_wdata", mm_s_wdata_o, 0);
        model_reset();
        idle_inputs();
        tick();
        rst_i = 0;
        m1_req_i = 1;
        tick();
        check_eq("post_rst_gnt", {m1_gnt_o, m0_gnt_o}, 2'b10);
        m1_req_i = 0;
        tick();
        tick();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if (!m0_req_i) m0_req_i = ($urandom_range(3) == 0);
            else if (owner == 0) m0_req_i = ($urandom_range(5) != 0);
            if (!m1_req_i) m1_req_i = ($urandom_range(3) == 0);
            else if (owner == 1) m1_req_i = ($urandom_range(5) != 0);
            m0_we_i = $urandom_range(1); m0_addr_i = AW'($urandom); m0_wdata_i = DW'($urandom);
            m1_we_i = $urandom_range(1); m1_addr_i = AW'($urandom); m1_wdata_i = DW'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
